// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  function automatic logic [KEY_W-1:0] key_encode(input logic [1:0] row_idx,
                                                  input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

  // Lowest-index active-low row wins when several rows read low together.
  function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] rows_n);
    logic [1:0] idx;
    if (!rows_n[0])      idx = 2'd0;
    else if (!rows_n[1]) idx = 2'd1;
    else if (!rows_n[2]) idx = 2'd2;
    else if (!rows_n[3]) idx = 2'd3;
    else                 idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV clocks.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce; KEY_REPEAT_EN adds auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEB_TICKS    = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  row_n,
  output logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  if (SCAN_DIV < 2)     begin : g_bad_div   $error("SCAN_DIV must be >= 2");     end
  if (DEB_TICKS < 1)    begin : g_bad_deb   $error("DEB_TICKS must be >= 1");    end
  if (REPEAT_DELAY < 1) begin : g_bad_delay $error("REPEAT_DELAY must be >= 1"); end
  if (REPEAT_RATE < 1)  begin : g_bad_rate  $error("REPEAT_RATE must be >= 1");  end

  localparam int DEB_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TICKS - 1);

  logic tick;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [ROWS-1:0]  row_meta_q, row_s_q;
  state_e           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             row_hit;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_WRAP  = REP_W'(REPEAT_DELAY + REPEAT_RATE);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_next;
`endif

  // Two-flop synchronizer; idle rows read high through the pull-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_s_q    <= '1;
    end else begin
      row_meta_q <= row_n;
      row_s_q    <= row_meta_q;
    end
  end

  assign row_hit   = ~row_s_q[row_idx_q];
  assign col_n     = ~(COLS'(1) << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_next    = rep_cnt_q + REP_W'(1);
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_s_q != '1) begin
            row_idx_d = lowest_low_row(row_s_q);
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_hit) begin
            if (deb_cnt_q == DEB_LAST) begin
              key_code_d  = key_encode(row_idx_q, col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
`ifdef KEY_REPEAT_EN
              rep_cnt_d   = '0;
`endif
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        HELD: begin
          if (!row_hit) begin
            deb_cnt_d = '0;
            state_d   = RELEASE;
          end else begin
`ifdef KEY_REPEAT_EN
            // After the first repeat the counter folds back to REP_FIRST so it stays bounded.
            if (rep_next == REP_FIRST) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = rep_next;
            end else if (rep_next == REP_WRAP) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = REP_FIRST;
            end else begin
              rep_cnt_d   = rep_next;
            end
`endif
          end
        end
        RELEASE: begin
          if (row_hit) begin
            state_d = HELD;
          end else if (deb_cnt_q == DEB_LAST) begin
            key_held_d = 1'b0;
            state_d    = SCAN;
            col_idx_d  = col_idx_q + 2'd1;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      deb_cnt_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner; the repeat scenario expects extra pulses when KEY_REPEAT_EN is defined.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEB_TICKS    = 3;
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed = '0;
  logic [3:0]      exp_q[$];
  int              errors = 0;
  int              checks = 0;

  always #5 clk = ~clk;

  // Switch matrix: a closed switch pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r] & ~col_n);
  end

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEB_TICKS    (DEB_TICKS),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_held(input logic lvl, input int max, input string name);
    int n = 0;
    while (key_held !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, key_held}, {31'd0, lvl});
  endtask

  task automatic monitor();
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        chk("valid_gap", {31'd0, prev}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got key_code %0h expected no pulse", key_code);
        end else begin
          chk("key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
        end
      end
      prev = key_valid;
    end
  endtask

  initial begin
    logic [3:0] scan_exp[5];
    logic [3:0] prev_col;
    int n;
    scan_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_col", {28'd0, col_n}, 32'hE);
    chk("rst_code", {28'd0, key_code}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_held", {31'd0, key_held}, 32'd0);
    rst_n = 1'b1;

    // Idle scanning, one column step every SCAN_DIV clocks
    prev_col = col_n;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (col_n === prev_col && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("scan_col", {28'd0, col_n}, {28'd0, scan_exp[i]});
      chk("scan_period", n, 32'd4);
      chk("idle_held", {31'd0, key_held}, 32'd0);
      prev_col = col_n;
    end

    // Stable press row1/col2
    pressed[1][2] = 1'b1;
    exp_q.push_back(4'd6);
    wait_held(1'b1, 100, "t2_held");
    chk("t2_code", {28'd0, key_code}, 32'd6);
    chk("t2_col", {28'd0, col_n}, 32'hB);
    repeat (12) @(negedge clk);
    chk("t2_col_frozen", {28'd0, col_n}, 32'hB);
    chk("t2_still_held", {31'd0, key_held}, 32'd1);
    pressed = '0;
    wait_held(1'b0, 60, "t2_release");
    chk("t2_resume_col", {28'd0, col_n}, 32'h7);

    // Glitching press row3/col0: alternate every tick period, never 3 lows in a row
    for (int w = 0; w < 8; w++) begin
      pressed[3][0] = (w % 2 == 0);
      repeat (4) @(negedge clk);
    end
    chk("t3_no_held", {31'd0, key_held}, 32'd0);
    chk("t3_no_early", exp_q.size(), 32'd0);
    pressed[3][0] = 1'b1;
    exp_q.push_back(4'd12);
    wait_held(1'b1, 200, "t3_held");
    chk("t3_code", {28'd0, key_code}, 32'd12);
    pressed = '0;
    wait_held(1'b0, 80, "t3_release");

    // Release bounce row2/col1: two high ticks then low again
    pressed[2][1] = 1'b1;
    exp_q.push_back(4'd9);
    wait_held(1'b1, 100, "t4_held");
    pressed = '0;
    repeat (8) @(negedge clk);
    pressed[2][1] = 1'b1;
    chk("t4_bounce_held", {31'd0, key_held}, 32'd1);
    repeat (8) @(negedge clk);
    chk("t4_after_bounce", {31'd0, key_held}, 32'd1);
    chk("t4_code", {28'd0, key_code}, 32'd9);
    pressed = '0;
    repeat (8) @(negedge clk);
    chk("t4_partial_release", {31'd0, key_held}, 32'd1);
    wait_held(1'b0, 40, "t4_release");

    // Rows 1 and 2 on column 3, then async reset while held
    pressed[1][3] = 1'b1;
    pressed[2][3] = 1'b1;
    exp_q.push_back(4'd7);
    wait_held(1'b1, 100, "t5_held");
    chk("t5_code", {28'd0, key_code}, 32'd7);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_col", {28'd0, col_n}, 32'hE);
    chk("t5_rst_held", {31'd0, key_held}, 32'd0);
    chk("t5_rst_code", {28'd0, key_code}, 32'd0);
    chk("t5_rst_valid", {31'd0, key_valid}, 32'd0);
    pressed = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Long hold row0/col1 for 11 ticks after acceptance
    pressed[0][1] = 1'b1;
    exp_q.push_back(4'd1);
`ifdef KEY_REPEAT_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(4'd1);
`endif
    wait_held(1'b1, 100, "t6_held");
    chk("t6_code", {28'd0, key_code}, 32'd1);
    repeat (44) @(negedge clk);
    pressed = '0;
    wait_held(1'b0, 80, "t6_release");

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
